// File: rtl/sel_pipe_mux_if.sv
// Bus bundle for sel_pipe_mux: packed input channels, pipeline controls and registered outputs.
// The master drives the inputs and controls; the slave is the mux and drives the outputs.
interface sel_pipe_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 9,
  parameter int SELW  = 4
) ();
  logic [NCH*WIDTH-1:0] in_bus;
  logic [SELW-1:0]      sel;
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic                 err_clr;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic [SELW-1:0]      out_sel;
  logic                 sel_err;
  logic [7:0]           err_cnt;

  modport master (
    output in_bus, sel, in_valid, stall, flush, err_clr,
    input  out_data, out_valid, out_sel, sel_err, err_cnt
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush, err_clr,
    output out_data, out_valid, out_sel, sel_err, err_cnt
  );
endinterface

// File: rtl/sel_pipe_mux.sv
// Registered N-way channel select with stall/flush and a sticky, saturating
// out-of-range-select error monitor. Out-of-range selects route the last channel.
module sel_pipe_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 9,
  parameter int SELW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  sel_pipe_mux_if.slave bus
);

  generate
    if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("sel_pipe_mux: NCH must be in 2..16");
    end
    if (SELW < $clog2(NCH)) begin : g_bad_selw
      $error("sel_pipe_mux: SELW too narrow to address NCH channels");
    end
  endgenerate

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [WIDTH-1:0] chan [NCH];
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  eff_sel;
  logic             sel_oob;
  logic             err_event;

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  out_sel_reg;
  logic             sel_err_reg;
  logic [7:0]       err_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi] = bus.in_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // When NCH == 2**SELW, LAST_CH is all ones and sel_oob is constant 0.
  assign sel_oob   = (bus.sel > LAST_CH);
  assign eff_sel   = sel_oob ? LAST_CH : bus.sel;
  assign err_event = bus.in_valid & sel_oob & ~bus.stall & ~bus.flush;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (eff_sel == SELW'(k)) sel_data = chan[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
      sel_err_reg   <= 1'b0;
      err_cnt_reg   <= 8'd0;
    end else begin
      if (bus.flush) begin
        out_data_reg  <= '0;
        out_valid_reg <= 1'b0;
        out_sel_reg   <= '0;
      end else if (!bus.stall) begin
        out_data_reg  <= sel_data;
        out_valid_reg <= bus.in_valid;
        out_sel_reg   <= eff_sel;
      end

      // A simultaneous clear and error restart the count at one.
      if (err_event) begin
        sel_err_reg <= 1'b1;
        if (bus.err_clr)               err_cnt_reg <= 8'd1;
        else if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end else if (bus.err_clr) begin
        sel_err_reg <= 1'b0;
        err_cnt_reg <= 8'd0;
      end
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sel   = out_sel_reg;
  assign bus.sel_err   = sel_err_reg;
  assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed bench for sel_pipe_mux: default configuration driven through a scoreboard,
// plus a WIDTH=8/NCH=4/SELW=2 instance swept over every select.
module tb_sel_pipe_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  sel_pipe_mux_if #(.WIDTH(32), .NCH(9), .SELW(4)) bus ();
  sel_pipe_mux_if #(.WIDTH(8),  .NCH(4), .SELW(2)) bus2 ();

  sel_pipe_mux #(.WIDTH(32), .NCH(9), .SELW(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  sel_pipe_mux #(.WIDTH(8), .NCH(4), .SELW(2)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  logic [31:0] chan [9];
  logic [7:0]  chan2 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_bus
      assign bus.in_bus[gi*32 +: 32] = chan[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_bus2
      assign bus2.in_bus[gi*8 +: 8] = chan2[gi];
    end
  endgenerate

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic [3:0]  sel;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q [$];

  // Reference state of the default instance, built from the requirements.
  logic [31:0] m_data;
  logic        m_valid;
  logic [3:0]  m_sel;
  logic        m_err;
  logic [7:0]  m_cnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock of the default instance: drive, predict, push, then compare what pops out.
  task automatic step(input logic rst, input logic [3:0] s, input logic v,
                      input logic st, input logic fl, input logic ec, input string tag);
    exp_t e;
    logic [3:0] eff;
    logic ev;
    @(negedge clk);
    reset = rst; bus.sel = s; bus.in_valid = v;
    bus.stall = st; bus.flush = fl; bus.err_clr = ec;
    eff = (s > 4'd8) ? 4'd8 : s;
    ev  = v && (s > 4'd8) && !st && !fl;
    if (rst) begin
      m_data = '0; m_valid = 0; m_sel = '0; m_err = 0; m_cnt = 0;
    end else begin
      if (fl) begin
        m_data = '0; m_valid = 0; m_sel = '0;
      end else if (!st) begin
        m_data = chan[eff]; m_valid = v; m_sel = eff;
      end
      if (ev) begin
        m_err = 1;
        m_cnt = ec ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
      end else if (ec) begin
        m_err = 0; m_cnt = 0;
      end
    end
    e.data = m_data; e.valid = m_valid; e.sel = m_sel; e.err = m_err; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".data"},  bus.out_data,         e.data);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, e.valid});
    chk({tag, ".sel"},   {28'd0, bus.out_sel},   {28'd0, e.sel});
    chk({tag, ".err"},   {31'd0, bus.sel_err},   {31'd0, e.err});
    chk({tag, ".cnt"},   {24'd0, bus.err_cnt},   {24'd0, e.cnt});
  endtask

  initial begin
    for (int k = 0; k < 9; k++) chan[k] = 32'h1000_0000 + k;
    for (int k = 0; k < 4; k++) chan2[k] = 8'hA0 + 8'(k);
    bus.sel = 4'hF; bus.in_valid = 1; bus.stall = 0; bus.flush = 0; bus.err_clr = 0;
    bus2.sel = '0; bus2.in_valid = 0; bus2.stall = 0; bus2.flush = 0; bus2.err_clr = 0;

    // Reset with an error-looking input present.
    step(1, 4'hF, 1, 0, 0, 0, "reset");
    chk("reset.data_lit", bus.out_data, 32'h0);
    chk("reset.cnt_lit", {24'd0, bus.err_cnt}, 32'd0);

    // Sweep every legal select.
    for (int s = 0; s < 9; s++) begin
      step(0, 4'(s), 1, 0, 0, 0, $sformatf("sweep%0d", s));
      chk($sformatf("sweep%0d.lit", s), bus.out_data, 32'h1000_0000 + 32'(s));
    end

    // Out-of-range select routes channel 8 and flags an error only when valid.
    step(0, 4'hC, 1, 0, 0, 0, "oob_valid");
    chk("oob_valid.sel_lit", {28'd0, bus.out_sel}, 32'd8);
    chk("oob_valid.cnt_lit", {24'd0, bus.err_cnt}, 32'd1);
    step(0, 4'd0, 0, 0, 0, 1, "clr");
    step(0, 4'hC, 0, 0, 0, 0, "oob_invalid");
    chk("oob_invalid.data_lit", bus.out_data, 32'h1000_0008);
    chk("oob_invalid.err_lit", {31'd0, bus.sel_err}, 32'd0);

    // Load then hold through stall while inputs change; flush overrides stall.
    step(0, 4'd3, 1, 0, 0, 0, "load3");
    for (int k = 0; k < 9; k++) chan[k] = 32'h2000_0000 + k;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'd5, i[0], 1, 0, 0, $sformatf("stall%0d", i));
      chk($sformatf("stall%0d.lit", i), bus.out_data, 32'h1000_0003);
    end
    step(0, 4'hF, 1, 1, 0, 0, "stall_oob");
    step(0, 4'd5, 1, 1, 1, 0, "flush_stall");
    chk("flush_stall.valid_lit", {31'd0, bus.out_valid}, 32'd0);
    step(0, 4'd6, 1, 0, 0, 0, "after_flush");
    for (int k = 0; k < 9; k++) chan[k] = 32'h1000_0000 + k;

    // Saturation and clear interactions; flush alone keeps the error state.
    for (int i = 0; i < 300; i++) step(0, 4'hE, 1, 0, 0, 0, $sformatf("sat%0d", i));
    chk("sat.cnt_lit", {24'd0, bus.err_cnt}, 32'd255);
    step(0, 4'd2, 1, 0, 1, 0, "flush_keep_err");
    step(0, 4'hD, 1, 0, 0, 1, "clr_with_err");
    chk("clr_with_err.cnt_lit", {24'd0, bus.err_cnt}, 32'd1);
    step(0, 4'hD, 1, 1, 0, 1, "clr_during_stall");
    chk("clr_during_stall.cnt_lit", {24'd0, bus.err_cnt}, 32'd0);
    step(0, 4'hD, 1, 0, 1, 1, "flush_with_clr");
    step(0, 4'h9, 1, 0, 0, 0, "err_again");
    step(0, 4'h1, 1, 0, 0, 1, "clr_alone");

    // Mid-stream reset during an error event.
    step(0, 4'hA, 1, 0, 0, 0, "pre_reset");
    step(1, 4'hF, 1, 0, 0, 0, "mid_reset");
    chk("mid_reset.cnt_lit", {24'd0, bus.err_cnt}, 32'd0);
    step(0, 4'd7, 1, 0, 0, 0, "post_reset");

    // Power-of-two channel count: every select is legal.
    @(negedge clk);
    bus2.sel = 2'd3; bus2.in_valid = 1;
    @(posedge clk); #1;
    chk("n4.reset_data", {24'd0, bus2.out_data}, 32'd0);
    @(negedge clk);
    reset2 = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus2.sel = 2'(s); bus2.in_valid = 1;
      @(posedge clk); #1;
      chk($sformatf("n4.data%0d", s), {24'd0, bus2.out_data}, 32'hA0 + 32'(s));
      chk($sformatf("n4.sel%0d", s), {30'd0, bus2.out_sel}, 32'(s));
      chk($sformatf("n4.err%0d", s), {31'd0, bus2.sel_err}, 32'd0);
      chk($sformatf("n4.cnt%0d", s), {24'd0, bus2.err_cnt}, 32'd0);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
